// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and write-port types for the writeback arbiter.
// Register index/value widths live here so every consumer agrees on them.
package regfile_write_arbiter_pkg;

  localparam int REGISTER_NUMBER_LOG = 5;
  localparam int DATA_WIDTH          = 32;

  typedef logic [REGISTER_NUMBER_LOG-1:0] reg_index_t;
  typedef logic [DATA_WIDTH-1:0]          reg_value_t;

  typedef struct packed {
    reg_index_t index;
    reg_value_t value;
  } reg_write_t;

  // Register 0 is hardwired zero, so this write is a no-op for the register file.
  localparam reg_write_t IDLE_WRITE = '{index: '0, value: '0};

  function automatic logic read_hazard(input reg_index_t read_index,
                                       input reg_index_t write_index,
                                       input logic       pending_hit);
    return (read_index != '0) && ((read_index == write_index) || pending_hit);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback requests, register-file write port and read-port snoop signals.
// The master side is the requesters/register file, the slave side is the arbiter.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  localparam int GRANT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [NUM_REQ*REGISTER_NUMBER_LOG-1:0] req_index;
  logic [NUM_REQ*DATA_WIDTH-1:0]          req_value;

  reg_index_t                             writeIndex;
  reg_value_t                             writeValue;
  logic [GRANT_W-1:0]                     grant_id;

  reg_index_t                             readIndexA;
  reg_index_t                             readIndexB;
  logic                                   hazardA;
  logic                                   hazardB;

  modport master (
    output req_valid, req_index, req_value, readIndexA, readIndexB,
    input  req_ready, writeIndex, writeValue, grant_id, hazardA, hazardB
  );

  modport slave (
    input  req_valid, req_index, req_value, readIndexA, readIndexB,
    output req_ready, writeIndex, writeValue, grant_id, hazardA, hazardB
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant to the first requester at or after
// the pointer; the pointer moves past the winner only when the grant is consumed.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand_idx [N];
  logic          found;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  // Candidate k is the k-th requester in search order starting from the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand_idx[gi] = wrap_add(ptr_q, gi);
  end

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand_idx[k]]) begin
        found     = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    if (found && !reset) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = wrap_add(grant_idx, 1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback sources and
// flags register-file reads that would miss a pending or in-flight write.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] grant;
  logic [GRANT_W-1:0] grant_idx;
  logic               accept;
  reg_write_t         sel_write;
  reg_write_t         out_q, out_d;
  logic [GRANT_W-1:0] grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] hit_a, hit_b;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants only ever go to valid requesters, so any grant is an accept.
  assign accept        = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    sel_write = IDLE_WRITE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write.index = bus.req_index[i*REGISTER_NUMBER_LOG +: REGISTER_NUMBER_LOG];
        sel_write.value = bus.req_value[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    out_d      = IDLE_WRITE;
    grant_id_d = grant_id_q;
    if (accept) begin
      out_d      = sel_write;
      grant_id_d = grant_idx;
    end
  end

  // Reset drops any in-flight write; requesters re-present afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= IDLE_WRITE;
      grant_id_q <= '0;
    end else begin
      out_q      <= out_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign bus.writeIndex = out_q.index;
  assign bus.writeValue = out_q.value;
  assign bus.grant_id   = grant_id_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit_a
    assign hit_a[gi] = bus.req_valid[gi] &&
                       (bus.req_index[gi*REGISTER_NUMBER_LOG +: REGISTER_NUMBER_LOG] == bus.readIndexA);
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hit_b
    assign hit_b[gi] = bus.req_valid[gi] &&
                       (bus.req_index[gi*REGISTER_NUMBER_LOG +: REGISTER_NUMBER_LOG] == bus.readIndexB);
  end

  assign bus.hazardA = read_hazard(bus.readIndexA, out_q.index, |hit_a);
  assign bus.hazardB = read_hazard(bus.readIndexB, out_q.index, |hit_b);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter: per-cycle vectors check the combinational
// grant/hazard outputs, and a scoreboard queue checks the registered write one cycle later.
module tb_regfile_write_arbiter;

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [4:0]  i0;
    logic [31:0] d0;
    logic [4:0]  i1;
    logic [31:0] d1;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [1:0]  rdy;
    logic        ha;
    logic        hb;
    logic [4:0]  wi;
    logic [31:0] wv;
    logic        gid;
  } vec_t;

  typedef struct {
    logic [4:0]  wi;
    logic [31:0] wv;
    logic        gid;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter_if #(.NUM_REQ(2)) bus ();

  regfile_write_arbiter #(.NUM_REQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input int rst, input int v, input int i0, input int d0, input int i1,
                     input int d1, input int ra, input int rb, input int rdy, input int ha,
                     input int hb, input int wi, input int wv, input int gid);
    vec_t e;
    e.rst = 1'(rst); e.v  = 2'(v);  e.i0 = 5'(i0); e.d0 = 32'(d0);
    e.i1  = 5'(i1);  e.d1 = 32'(d1); e.ra = 5'(ra); e.rb = 5'(rb);
    e.rdy = 2'(rdy); e.ha = 1'(ha); e.hb = 1'(hb);
    e.wi  = 5'(wi);  e.wv = 32'(wv); e.gid = 1'(gid);
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input int row, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic pop_check(input int row);
    out_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("writeIndex", row, 64'(bus.writeIndex), 64'(e.wi));
    chk("writeValue", row, 64'(bus.writeValue), 64'(e.wv));
    chk("grant_id",   row, 64'(bus.grant_id),   64'(e.gid));
  endtask

  // Entered just after a rising edge; leaves just after the next rising edge.
  task automatic step(input vec_t v, input int row);
    out_t o;
    reset          = v.rst;
    bus.req_valid  = v.v;
    bus.req_index  = {v.i1, v.i0};
    bus.req_value  = {v.d1, v.d0};
    bus.readIndexA = v.ra;
    bus.readIndexB = v.rb;
    @(negedge clk);
    chk("req_ready", row, 64'(bus.req_ready), 64'(v.rdy));
    chk("hazardA",   row, 64'(bus.hazardA),   64'(v.ha));
    chk("hazardB",   row, 64'(bus.hazardB),   64'(v.hb));
    pop_check(row);
    o.wi = v.wi; o.wv = v.wv; o.gid = v.gid;
    sb.push_back(o);
    $display("row %0d rst=%0b valid=%b ready=%b hzA=%0b hzB=%0b wIdx=%0d wVal=%0d gid=%0d",
             row, v.rst, v.v, bus.req_ready, bus.hazardA, bus.hazardB,
             bus.writeIndex, bus.writeValue, bus.grant_id);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t h;
    //   rst v  i0  d0  i1  d1 ra rb rdy hA hB  wi  wv gid
    add(1, 3,  1, 11,  2, 22, 0, 0, 0, 0, 0,  0,  0, 0);
    add(1, 3,  1, 11,  2, 22, 0, 0, 0, 0, 0,  0,  0, 0);
    add(0, 3,  1, 11,  2, 22, 0, 0, 1, 0, 0,  1, 11, 0);
    add(0, 2,  1, 11,  2, 22, 0, 0, 2, 0, 0,  2, 22, 1);
    add(0, 1,  3,  7,  0,  0, 0, 0, 1, 0, 0,  3,  7, 0);
    add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,  0,  0, 0);
    add(0, 2,  0,  0,  0, 99, 0, 0, 2, 0, 0,  0, 99, 1);
    add(0, 3,  2, 20,  5, 50, 0, 0, 1, 0, 0,  2, 20, 0);
    add(0, 2,  2, 20,  5, 50, 0, 0, 2, 0, 0,  5, 50, 1);
    add(0, 3,  6, 60,  7, 70, 0, 0, 1, 0, 0,  6, 60, 0);
    add(0, 2,  6, 60,  7, 70, 0, 0, 2, 0, 0,  7, 70, 1);
    add(0, 1,  8, 80,  0,  0, 0, 0, 1, 0, 0,  8, 80, 0);
    add(0, 1, 10,100,  0,  0, 0, 0, 1, 0, 0, 10,100, 0);
    add(0, 3, 11,110, 12,120, 0, 0, 2, 0, 0, 12,120, 1);
    add(0, 3, 11,110, 13,130, 0, 0, 1, 0, 0, 11,110, 0);
    add(0, 3, 14,140, 13,130, 0, 0, 2, 0, 0, 13,130, 1);
    add(0, 3, 14,140, 15,150, 0, 0, 1, 0, 0, 14,140, 0);
    add(0, 0,  0,  0,  0,  0, 9, 0, 0, 0, 0,  0,  0, 0);
    add(0, 2,  0,  0,  9, 90, 9,14, 2, 1, 0,  9, 90, 1);
    add(0, 0,  0,  0,  0,  0, 9, 9, 0, 1, 1,  0,  0, 1);
    add(0, 0,  0,  0,  0,  0, 9, 0, 0, 0, 0,  0,  0, 1);
    add(0, 3,  0,  5, 17,170,17, 0, 1, 1, 0,  0,  5, 0);
    add(0, 2,  0,  5, 17,170,17,17, 2, 1, 1, 17,170, 1);
    add(0, 1,  4, 44,  0,  0, 4, 0, 1, 1, 0,  4, 44, 0);
    add(1, 1,  4, 44,  0,  0, 4, 0, 0, 1, 0,  0,  0, 0);
    add(0, 3,  4, 44, 21,210, 0,21, 1, 0, 1,  4, 44, 0);
    add(0, 2,  4, 44, 21,210, 4, 0, 2, 1, 0, 21,210, 1);
    add(0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0,  0,  0, 1);

    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_index  = '0;
    bus.req_value  = '0;
    bus.readIndexA = '0;
    bus.readIndexB = '0;
    @(posedge clk);
    #1;

    for (int r = 0; r < vecs.size(); r++) step(vecs[r], r);

    // Sustained contention: each payload only changes after its own accept.
    for (int c = 0; c < 6; c++) begin
      h.rst = 1'b0; h.v = 2'b11; h.ra = '0; h.rb = '0; h.ha = 1'b0; h.hb = 1'b0;
      h.i0  = 5'(1 + (c + 1) / 2);  h.d0 = 32'(100 + (c + 1) / 2);
      h.i1  = 5'(20 + c / 2);       h.d1 = 32'(200 + c / 2);
      h.rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      h.gid = 1'(c % 2);
      h.wi  = (c % 2 == 0) ? h.i0 : h.i1;
      h.wv  = (c % 2 == 0) ? h.d0 : h.d1;
      step(h, 100 + c);
    end

    reset         = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    pop_check(200);
    chk("scoreboard_drained", 200, 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
